// File: rtl/kuz_sbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kuz_sbox_sequencer
// Description : Kuznyechik S-layer sequencer. Accepts one 128-bit block,
//               pushes it through LANES external combinational pi S-boxes,
//               LANES bytes per cycle over STEPS = 16/LANES cycles, and then
//               presents the substituted block to the downstream stage.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               in_valid/ready - input handshake (ready only while idle)
//               in_data        - block, byte 0 = [127:120], byte 15 = [7:0]
//               sbox_in        - lookup addresses, lane k = [8k+7:8k]
//               sbox_out       - S-box results, lane-aligned with sbox_in
//               out_valid/ready- output handshake
//               out_data       - substituted block, same byte order
//               busy           - block in flight (RUN or DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module kuz_sbox_sequencer #(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [8*LANES-1:0]   sbox_in,
  input  logic [8*LANES-1:0]   sbox_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);

  // Guarded division keeps elaboration alive long enough to reach the check.
  localparam int STEPS = (LANES > 0) ? (16 / LANES) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_bad_lanes
      $error("kuz_sbox_sequencer: LANES must divide 16 (1, 2, 4, 8 or 16)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       wreg;
  logic [127:0]       wreg_nxt;

  // Lane k works on byte cnt*LANES+k. Byte b sits at bit offset 8*(15-b),
  // which for a 4-bit b is simply {~b, 3'b000}.
  always_comb begin : comb_lanes
    logic [3:0] bidx;
    bidx     = '0;
    wreg_nxt = wreg;
    sbox_in  = '0;
    for (int k = 0; k < LANES; k++) begin
      bidx = 4'(int'(cnt) * LANES + k);
      sbox_in[8*k +: 8]               = wreg[{~bidx, 3'b000} +: 8];
      wreg_nxt[{~bidx, 3'b000} +: 8]  = sbox_out[8*k +: 8];
    end
  end

  assign out_data = wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wreg      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wreg     <= in_data;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          wreg <= wreg_nxt;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // wreg is left untouched here so out_data holds under backpressure.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kuz_sbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kuz_sbox_sequencer
// Description : Self-checking bench for kuz_sbox_sequencer, one instance with
//               LANES=1 and one with LANES=4, each fed by a pi S-box model.
//               Expected blocks go into per-instance queues; monitors pop and
//               compare on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kuz_sbox_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LANES=1 instance
  logic         u1_in_valid = 1'b0, u1_in_ready, u1_out_valid, u1_out_ready = 1'b1, u1_busy;
  logic [127:0] u1_in_data = '0, u1_out_data;
  logic [7:0]   u1_sbox_in, u1_sbox_out;
  // LANES=4 instance
  logic         u4_in_valid = 1'b0, u4_in_ready, u4_out_valid, u4_out_ready = 1'b1, u4_busy;
  logic [127:0] u4_in_data = '0, u4_out_data;
  logic [31:0]  u4_sbox_in, u4_sbox_out;

  kuz_sbox_sequencer #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_data(u1_in_data), .sbox_in(u1_sbox_in), .sbox_out(u1_sbox_out),
    .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_data(u1_out_data),
    .busy(u1_busy));

  kuz_sbox_sequencer #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .in_data(u4_in_data), .sbox_in(u4_sbox_in), .sbox_out(u4_sbox_out),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .out_data(u4_out_data),
    .busy(u4_busy));

  // Kuznyechik pi for the addresses the vectors use; other addresses map to
  // a non-identity filler so a stray lookup still corrupts the result.
  function automatic logic [7:0] pi(input logic [7:0] x);
    case (x)
      8'h00: pi = 8'hFC;  8'h01: pi = 8'hEE;  8'h02: pi = 8'hDD;  8'h03: pi = 8'h11;
      8'h04: pi = 8'hCF;  8'h05: pi = 8'h6E;  8'h06: pi = 8'h31;  8'h07: pi = 8'h16;
      default: pi = x ^ 8'hA5;
    endcase
  endfunction

  assign u1_sbox_out = pi(u1_sbox_in);
  always_comb begin
    u4_sbox_out = '0;
    for (int k = 0; k < 4; k++) u4_sbox_out[8*k +: 8] = pi(u4_sbox_in[8*k +: 8]);
  end

  int checks = 0;
  int errors = 0;
  logic [127:0] q1[$];
  logic [127:0] q4[$];

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitors: sampled on the falling edge, ahead of the handshake edge.
  initial forever begin
    @(negedge clk);
    if (!rst && u1_out_valid && u1_out_ready) begin
      if (q1.size() == 0) chk("mon1_unexpected_output", u1_out_data, 128'hx);
      else chk("mon1_data", u1_out_data, q1.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst && u4_out_valid && u4_out_ready) begin
      if (q4.size() == 0) chk("mon4_unexpected_output", u4_out_data, 128'hx);
      else chk("mon4_data", u4_out_data, q4.pop_front());
    end
  end

  // Drive a block into dut1 until accepted; returns at accept edge + 1.
  task automatic accept1(input logic [127:0] d, input logic [127:0] e, input bit push);
    int n = 0;
    u1_in_data = d; u1_in_valid = 1'b1;
    while (!u1_in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!u1_in_ready) chk("accept1_timeout", 0, 1);
    if (push) q1.push_back(e);
    @(posedge clk); #1;
    u1_in_valid = 1'b0;
  endtask

  task automatic accept4(input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    u4_in_data = d; u4_in_valid = 1'b1;
    while (!u4_in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!u4_in_ready) chk("accept4_timeout", 0, 1);
    q4.push_back(e);
    @(posedge clk); #1;
    u4_in_valid = 1'b0;
  endtask

  // Cycles from acceptance to out_valid, and how long in_ready stayed low.
  task automatic measure1(output int lat, output int low);
    lat = -1; low = 0;
    for (int c = 0; c < 40; c++) begin
      if (!u1_in_ready) low++;
      if (u1_out_valid && lat < 0) lat = c;
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] g4[4];
  task automatic measure4(output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) g4[c] = u4_sbox_in;
      if (u4_out_valid && lat < 0) lat = c;
      @(posedge clk); #1;
    end
  endtask

  localparam logic [127:0] VEC_A = 128'h00010203040506070001020304050607;
  localparam logic [127:0] EXP_A = 128'hFCEEDD11CF6E3116FCEEDD11CF6E3116;
  localparam logic [127:0] VEC_B = 128'h07060504030201000001020304050607;
  localparam logic [127:0] EXP_B = 128'h16316ECF11DDEEFCFCEEDD11CF6E3116;

  initial begin
    int lat, low, n, cyc, last, idx;
    logic [127:0] held;
    logic [127:0] bd[3];
    logic [127:0] be[3];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready1", u1_in_ready, 1);
    chk("rst_out_valid1", u1_out_valid, 0);
    chk("rst_busy1", u1_busy, 0);
    chk("rst_out_data1", u1_out_data, 0);
    chk("rst_in_ready4", u4_in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero block: latency 16, in_ready low 17 cycles
    accept1(128'h0, {16{8'hFC}}, 1);
    measure1(lat, low);
    chk("l1_zero_latency", lat, 16);
    chk("l1_zero_in_ready_low", low, 17);

    // Byte-order vectors
    accept1(VEC_A, EXP_A, 1);
    measure1(lat, low);
    chk("l1_veca_latency", lat, 16);
    accept1(VEC_B, EXP_B, 1);
    measure1(lat, low);
    chk("l1_vecb_latency", lat, 16);

    // Backpressure for 10 cycles with a competing input offered
    u1_out_ready = 1'b0;
    accept1(VEC_B, EXP_B, 1);
    n = 0;
    while (!u1_out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_reach_done", u1_out_valid, 1);
    held = u1_out_data;
    chk("bp_data_value", held, EXP_B);
    u1_in_data = {16{8'h07}}; u1_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", u1_out_valid, 1);
      chk("bp_out_data_stable", u1_out_data, held);
      chk("bp_in_ready", u1_in_ready, 0);
      @(posedge clk); #1;
    end
    u1_in_valid = 1'b0; u1_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", u1_in_ready, 1);
    chk("bp_release_out_valid", u1_out_valid, 0);
    chk("bp_release_busy", u1_busy, 0);

    // Reset at RUN step 7; block discarded, in_valid during reset ignored
    accept1({16{8'h03}}, '0, 0);
    repeat (7) begin @(posedge clk); #1; end
    chk("mid_run_busy", u1_busy, 1);
    rst = 1'b1; u1_in_data = {16{8'h01}}; u1_in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_out_valid", u1_out_valid, 0);
    chk("rst_run_busy", u1_busy, 0);
    chk("rst_run_in_ready", u1_in_ready, 1);
    chk("rst_run_wreg", u1_out_data, 0);
    rst = 1'b0; u1_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_accept_busy", u1_busy, 0);
    accept1({16{8'h01}}, {16{8'hEE}}, 1);
    measure1(lat, low);
    chk("after_rst_latency", lat, 16);

    // LANES=4
    accept4({16{8'h02}}, {16{8'hDD}});
    measure4(lat);
    chk("l4_latency", lat, 4);
    accept4(VEC_B, EXP_B);
    measure4(lat);
    chk("l4_vecb_latency", lat, 4);
    chk("l4_group0", g4[0], 32'h04050607);
    chk("l4_group1", g4[1], 32'h00010203);
    chk("l4_group2", g4[2], 32'h03020100);
    chk("l4_group3", g4[3], 32'h07060504);

    // Back-to-back, in_valid held high
    bd[0] = VEC_A;          be[0] = EXP_A;
    bd[1] = VEC_B;          be[1] = EXP_B;
    bd[2] = {16{8'h05}};    be[2] = {16{8'h6E}};
    idx = 0; cyc = 0; last = -1;
    u1_out_ready = 1'b1; u1_in_data = bd[0]; u1_in_valid = 1'b1;
    while (idx < 3 && cyc < 200) begin
      if (u1_in_ready) begin
        q1.push_back(be[idx]);
        if (idx > 0) chk("b2b_interval", cyc - last, 18);
        last = cyc;
        idx++;
        @(posedge clk); #1; cyc++;
        if (idx < 3) u1_in_data = bd[idx];
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    u1_in_valid = 1'b0;
    if (idx < 3) chk("b2b_accept_timeout", idx, 3);

    // Drain
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 60) begin @(posedge clk); #1; n++; end
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
